// File: rtl/mano_axi_master_pkg.sv
// Shared definitions for the Mano CPU AXI4-Lite initiator: FSM encoding and AXI response codes.
package mano_axi_master_pkg;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_RESP      = 3'd2;
    localparam logic [2:0] ST_RD_ADDR      = 3'd3;
    localparam logic [2:0] ST_RD_DATA      = 3'd4;
    localparam logic [2:0] ST_DONE         = 3'd5;

    typedef enum logic [2:0] {
        StIdle       = ST_IDLE,
        StWrAddrData = ST_WR_ADDR_DATA,
        StWrResp     = ST_WR_RESP,
        StRdAddr     = ST_RD_ADDR,
        StRdData     = ST_RD_DATA,
        StDone       = ST_DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/mano_axi_master.sv
// AXI4-Lite initiator: turns one Mano CPU word request into a single AXI4-Lite read or write.
// Every output comes straight from a flop; next values are computed from the next FSM state.
module mano_axi_master
    import mano_axi_master_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH     = 12,
    parameter int unsigned MEM_DATA_WIDTH     = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_BASE_ADDR = 32'h4000_0000
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,

    input  logic                            cpu_req,
    input  logic [MEM_ADDR_WIDTH-1:0]       cpu_addr,
    input  logic                            cpu_we,
    input  logic [MEM_DATA_WIDTH-1:0]       cpu_d,
    output logic [MEM_DATA_WIDTH-1:0]       cpu_q,
    output logic                            cpu_busy,
    output logic                            cpu_done,
    output logic                            cpu_err,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                      m00_axi_awprot,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,

    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    state_e                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MEM_DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic                            aw_hs;
    logic                            w_hs;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   byte_addr;

    // Word address scaled to bytes; overflow past the top of the space wraps silently.
    assign byte_addr = C_M_TARGET_BASE_ADDR + C_M_AXI_ADDR_WIDTH'({cpu_addr, 2'b00});

    assign aw_hs = awvalid_q & m00_axi_awready;
    assign w_hs  = wvalid_q & m00_axi_wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d  = byte_addr;
                    wdata_d = C_M_AXI_DATA_WIDTH'(cpu_d);
                    if (cpu_we) begin
                        state_d   = StWrAddrData;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = StRdAddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrAddrData: begin
                // AW and W complete independently, in either order or together.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (m00_axi_bvalid) begin
                    state_d  = StDone;
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (m00_axi_bresp != RESP_OKAY);
                end
            end
            StRdAddr: begin
                if (m00_axi_arready) begin
                    state_d   = StRdData;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdData: begin
                if (m00_axi_rvalid) begin
                    state_d  = StDone;
                    rready_d = 1'b0;
                    rdata_d  = MEM_DATA_WIDTH'(m00_axi_rdata);
                    done_d   = 1'b1;
                    err_d    = (m00_axi_rresp != RESP_OKAY);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign cpu_q           = rdata_q;
    assign cpu_busy        = busy_q;
    assign cpu_done        = done_q;
    assign cpu_err         = err_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_mano_axi_master.sv
// Directed bench for mano_axi_master: the bench plays the AXI slave cycle by cycle.
module tb_mano_axi_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_d, cpu_q;
    logic        busy, done, err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int bready_cnt = 0;
    logic bready_prev = 1'b0;

    always #5 clk = ~clk;

    mano_axi_master dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .cpu_req         (cpu_req),
        .cpu_addr        (cpu_addr),
        .cpu_we          (cpu_we),
        .cpu_d           (cpu_d),
        .cpu_q           (cpu_q),
        .cpu_busy        (busy),
        .cpu_done        (done),
        .cpu_err         (err),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    // Count completion pulses and distinct bready phases.
    always @(posedge clk) begin
        if (done) done_cnt++;
        if (bready && !bready_prev) bready_cnt++;
        bready_prev = bready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_d = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, err}, 0);
        chk("reset_awaddr", awaddr, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_cpu_q", cpu_q, 0);
        rst_n = 1'b1;
        step();

        // Write, zero-wait slave
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_d = 32'hDEAD_BEEF;
        step();
        cpu_req = 1'b0;
        chk("wr0_valids", {awvalid, wvalid, busy}, 3'b111);
        chk("wr0_awaddr", awaddr, 32'h4000_0040);
        chk("wr0_wdata", wdata, 32'hDEAD_BEEF);
        chk("wr0_wstrb", wstrb, 4'hF);
        chk("wr0_prot", {awprot, arprot}, 6'b0);
        awready = 1'b1; wready = 1'b1;
        step();
        chk("wr0_hs", {awvalid, wvalid, bready, done}, 4'b0010);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        step();
        chk("wr0_done", {done, err, bready, busy}, 4'b1001);
        bvalid = 1'b0;
        step();
        chk("wr0_idle", {done, err, busy}, 3'b000);
        chk("wr0_done_cnt", done_cnt, 1);

        // Read with 4-cycle arready and 3-cycle rvalid delay
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        step();
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_ar_hold", {arvalid, rready, done}, 3'b100);
            chk("rd_araddr", araddr, 32'h4000_048C);
            step();
        end
        chk("rd_ar_last", {arvalid, rready}, 2'b10);
        chk("rd_araddr_last", araddr, 32'h4000_048C);
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_r_wait", {arvalid, rready, done}, 3'b010);
            step();
        end
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        step();
        rvalid = 1'b0; rdata = '0;
        chk("rd_done", {done, err, rready}, 3'b100);
        chk("rd_cpu_q", cpu_q, 32'h1234_5678);
        step();
        chk("rd_after", {done, busy}, 2'b00);
        chk("rd_cpu_q_hold", cpu_q, 32'h1234_5678);
        chk("rd_done_cnt", done_cnt, 2);

        // Write, wready two cycles before awready
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h3FF; cpu_d = 32'hA5A5_5A5A;
        step();
        cpu_req = 1'b0;
        chk("wa_awaddr", awaddr, 32'h4000_0FFC);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("wa_w_first", {awvalid, wvalid, bready}, 3'b100);
        step();
        chk("wa_aw_wait", {awvalid, wvalid, bready}, 3'b100);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("wa_resp", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        chk("wa_done", {done, err}, 2'b10);
        step();

        // Write, awready two cycles before wready, SLVERR response
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h001; cpu_d = 32'h0000_0001;
        step();
        cpu_req = 1'b0;
        chk("wb_awaddr", awaddr, 32'h4000_0004);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("wb_aw_first", {awvalid, wvalid, bready}, 3'b010);
        step();
        chk("wb_w_wait", {awvalid, wvalid, bready}, 3'b010);
        chk("wb_wdata", wdata, 32'h0000_0001);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("wb_resp", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b10;
        step();
        bvalid = 1'b0; bresp = 2'b00;
        chk("wb_done_err", {done, err}, 2'b11);
        step();
        chk("wb_err_clear", {done, err}, 2'b00);
        chk("bready_phases", bready_cnt, 3);
        chk("wb_done_cnt", done_cnt, 4);

        // Read with DECERR: data still captured
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0FF;
        step();
        cpu_req = 1'b0;
        chk("re_araddr", araddr, 32'h4000_03FC);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b11;
        step();
        rvalid = 1'b0; rresp = 2'b00;
        chk("re_done_err", {done, err}, 2'b11);
        chk("re_cpu_q", cpu_q, 32'hCAFE_F00D);
        step();
        chk("re_err_clear", {done, err}, 2'b00);

        // cpu_req held high: second request starts only from IDLE
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h002;
        step();
        chk("rh_araddr0", araddr, 32'h4000_0008);
        cpu_addr = 12'h003;
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("rh_busy_ignore", {arvalid, rready}, 2'b01);
        chk("rh_araddr_stable", araddr, 32'h4000_0008);
        rvalid = 1'b1; rdata = 32'h0000_0002;
        step();
        rvalid = 1'b0;
        chk("rh_done0", {done, busy}, 2'b11);
        step();
        chk("rh_idle_gap", {busy, arvalid}, 2'b00);
        step();
        cpu_req = 1'b0;
        chk("rh_second", {arvalid, busy}, 2'b11);
        chk("rh_araddr1", araddr, 32'h4000_000C);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0003;
        step();
        rvalid = 1'b0;
        chk("rh_done1", done, 1'b1);
        chk("rh_cpu_q", cpu_q, 32'h0000_0003);
        step();

        // Request pulsed while a write is busy
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h004; cpu_d = 32'h0000_0044;
        step();
        cpu_addr = 12'h005; cpu_we = 1'b0;
        step();
        cpu_req = 1'b0;
        chk("pb_aw_hold", {awvalid, wvalid, arvalid}, 3'b110);
        chk("pb_awaddr", awaddr, 32'h4000_0010);
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("pb_done", done, 1'b1);
        step();
        chk("pb_no_extra", {busy, arvalid, awvalid}, 3'b000);
        chk("pb_done_cnt", done_cnt, 8);

        // Reset asserted while waiting for the write response
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h006; cpu_d = 32'h0000_0066;
        step();
        cpu_req = 1'b0;
        awready = 1'b1; wready = 1'b1;
        step();
        awready = 1'b0; wready = 1'b0;
        chk("rs_in_resp", bready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, done, err}, 0);
        chk("rs_addr_data", {awaddr, wdata}, 0);
        chk("rs_cpu_q", cpu_q, 0);
        bvalid = 1'b1;
        step();
        step();
        bvalid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rs_no_done", done_cnt, 8);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h007;
        step();
        cpu_req = 1'b0;
        chk("rs_rd_araddr", araddr, 32'h4000_001C);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h7777_0007;
        step();
        rvalid = 1'b0;
        chk("rs_rd_done", {done, err}, 2'b10);
        chk("rs_rd_cpu_q", cpu_q, 32'h7777_0007);
        step();
        chk("rs_final_cnt", done_cnt, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
